// File: rtl/instr_fetch_unit_if.sv
// Fetch port bundle: instruction memory read port, redirect request and decode handshake.
// The misalign_o member exists only when FETCH_MISALIGN_TRAP_EN is defined.
interface instr_fetch_unit_if;
  logic        fetch_en_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] iaddr_o;
  logic        ird_o;
  logic [31:0] irdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign_o;

  modport master (
    input  fetch_en_i, redirect_i, redirect_pc_i, irdata_i, instr_ready_i,
    output iaddr_o, ird_o, instr_valid_o, instr_o, instr_pc_o, misalign_o
  );

  modport slave (
    output fetch_en_i, redirect_i, redirect_pc_i, irdata_i, instr_ready_i,
    input  iaddr_o, ird_o, instr_valid_o, instr_o, instr_pc_o, misalign_o
  );
`else
  modport master (
    input  fetch_en_i, redirect_i, redirect_pc_i, irdata_i, instr_ready_i,
    output iaddr_o, ird_o, instr_valid_o, instr_o, instr_pc_o
  );

  modport slave (
    output fetch_en_i, redirect_i, redirect_pc_i, irdata_i, instr_ready_i,
    input  iaddr_o, ird_o, instr_valid_o, instr_o, instr_pc_o
  );
`endif
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, one combinational memory read per cycle, prefetch FIFO toward decode.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect targets raise misalign_o and block issue.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input logic                clk_i,
  input logic                reset_i,
  instr_fetch_unit_if.master bus
);

  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [31:0]   pc_r;
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic [31:0]   fifo_instr_r [DEPTH];
  logic [31:0]   fifo_pc_r    [DEPTH];
  logic          misalign_r;
  logic          issue_s;
  logic          pop_s;
  logic          valid_s;

  // Issue/pop decision; a full FIFO blocks issue even when a pop happens this cycle
  always_comb begin
    issue_s = 1'b0;
    valid_s = (count_r != (AW + 1)'(0));
    pop_s   = 1'b0;
    if (!reset_i && !bus.redirect_i && bus.fetch_en_i && (count_r < DEPTH_C) && !misalign_r) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
    if (valid_s && bus.instr_ready_i) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Output drive: memory port follows the PC, decode sees the FIFO head or zero
  always_comb begin
    bus.iaddr_o       = pc_r;
    bus.ird_o         = issue_s;
    bus.instr_valid_o = valid_s;
    bus.instr_o       = 32'h0000_0000;
    bus.instr_pc_o    = 32'h0000_0000;
    if (valid_s) begin
      bus.instr_o    = fifo_instr_r[rd_ptr_r];
      bus.instr_pc_o = fifo_pc_r[rd_ptr_r];
    end else begin
      bus.instr_o    = 32'h0000_0000;
      bus.instr_pc_o = 32'h0000_0000;
    end
  end

  // PC and FIFO bookkeeping; reset beats redirect beats push/pop
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_r     <= RESET_PC;
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= (AW + 1)'(0);
    end else if (bus.redirect_i) begin
      // Masking (rather than slicing) keeps every target bit in use; low bits are dropped
      pc_r     <= bus.redirect_pc_i & 32'hFFFF_FFFC;
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= (AW + 1)'(0);
    end else begin
      if (issue_s) begin
        pc_r     <= pc_r + 32'd4;
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end else begin
        pc_r     <= pc_r;
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({issue_s, pop_s})
        2'b10:   count_r <= count_r + (AW + 1)'(1);
        2'b01:   count_r <= count_r - (AW + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage: word and its PC written together on issue
  always_ff @(posedge clk_i) begin
    if (issue_s) begin
      fifo_instr_r[wr_ptr_r] <= bus.irdata_i;
      fifo_pc_r[wr_ptr_r]    <= pc_r;
    end else begin
      fifo_instr_r[wr_ptr_r] <= fifo_instr_r[wr_ptr_r];
      fifo_pc_r[wr_ptr_r]    <= fifo_pc_r[wr_ptr_r];
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  // Misalign trap state: set by a misaligned redirect, cleared by an aligned one
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      misalign_r <= 1'b0;
    end else if (bus.redirect_i) begin
      misalign_r <= (bus.redirect_pc_i[1:0] != 2'b00);
    end else begin
      misalign_r <= misalign_r;
    end
  end

  assign bus.misalign_o = misalign_r;
`else
  assign misalign_r = 1'b0;
`endif

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch-side initiator for the combinational instruction memory port (iaddr/ird/irdata).
- Holds the PC and issues one word read per cycle.
- Captures returned words with their PC into a small prefetch FIFO and presents them to decode over a valid/ready handshake.
- Handles PC redirects from branch/jump resolution by flushing and refetching.

Parameters:
- RESET_PC, 32'h0000_0000: PC loaded on reset. Bits [1:0] must be 0.
- DEPTH, 4: prefetch FIFO entries. Power of 2, at least 2.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- reset_i  input  1  synchronous reset, active high.
- fetch_en_i  input  1  fetch enable; 0 stalls issue but still permits drain.
- redirect_i  input  1  redirect request (branch taken / jump / trap).
- redirect_pc_i  input  32  redirect target.
- iaddr_o  output  32  instruction memory address, always equal to current fetch PC.
- ird_o  output  1  instruction memory read strobe.
- irdata_i  input  32  instruction memory read data, valid in the same cycle as ird_o.
- instr_valid_o  output  1  FIFO head valid.
- instr_o  output  32  head instruction word.
- instr_pc_o  output  32  PC of head instruction.
- instr_ready_i  input  1  decode accepts head.

Behaviour:
- Reset (reset_i=1 at edge):
  - pc <= RESET_PC; FIFO count, read pointer and write pointer <= 0.
  - After reset: instr_valid_o=0, instr_o=0, instr_pc_o=0, ird_o=0 while reset_i=1, iaddr_o=RESET_PC.
  - Reset mid-operation discards all buffered entries.
- Issue (combinational): ird_o = !reset_i && !redirect_i && fetch_en_i && (count < DEPTH).
  - A full FIFO blocks issue even if a pop occurs in the same cycle. Max steady throughput is 1/cycle while count < DEPTH.
- On an issue edge: push {irdata_i, pc} into FIFO; pc <= pc + 4 (mod 2^32, so 32'hFFFF_FFFC wraps to 0).
- Pop: occurs on an edge where instr_valid_o && instr_ready_i.
  - instr_valid_o = (count != 0); instr_o / instr_pc_o = head entry, 0 when empty.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Redirect: priority is reset > redirect > push/pop.
  - On a redirect edge: count and pointers <= 0 (pop ignored), no push, pc <= {redirect_pc_i[31:2], 2'b00}.
  - Redirect at edge N: first issue from the new PC in cycle N+1; instr_valid_o first 1 in cycle N+2.
  - Back-to-back redirects: the last one wins.
- Latency: reset released before cycle 0 → issue at PC=RESET_PC in cycle 0 → instr_valid_o=1 in cycle 1.
- fetch_en_i=0: no issue, pc held, FIFO drains normally.
- Entries leave in strict program order. No entry is duplicated or dropped except by flush.
- irdata_i is sampled only when ird_o=1; its value is ignored otherwise.

Optional Feature:
- Macro FETCH_MISALIGN_TRAP_EN.
- When defined:
  - Extra output misalign_o (1 bit).
  - A redirect with redirect_pc_i[1:0] != 0 sets misalign_o=1 from the next cycle, forces pc to the aligned value, and blocks issue.
  - misalign_o and the blocking state persist until the next redirect with aligned target (clears it) or reset.
  - misalign_o reset value is 0.
- When undefined:
  - No misalign_o port.
  - Low bits are silently truncated and issue continues.

Test Plan:
(Bench memory model: irdata_i = iaddr_o ^ 32'hA5A5_0000 when ird_o=1, else 0.)
- Reset release, instr_ready_i=1, fetch_en_i=1 → cycle 1: instr_pc_o=0x0, instr_o=0xA5A50000. Cycle 2: pc 0x4, instr 0xA5A50004. Continuous 1/cycle stream.
- instr_ready_i=0 for 10 cycles → ird_o drops after 4 issues; count=4; heads hold 0x0. Raising ready releases 0x0, 0x4, 0x8, 0xC in order with no gaps or duplicates.
- With 3 entries buffered, pulse redirect_i with redirect_pc_i=0x100 together with instr_ready_i=1 → next cycle instr_valid_o=0, iaddr_o=0x100, ird_o=1. Cycle after: instr_pc_o=0x100, instr_o=0xA5A50100.
- Redirect to 0xFFFF_FFF8 → delivered PCs are 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000. instr_o at 0x0 = 0xA5A50000.
- Assert reset_i for one cycle while FIFO full → instr_valid_o=0 next cycle, iaddr_o=RESET_PC. fetch_en_i=0 for 5 cycles → ird_o=0 throughout, pc unchanged.
- With FETCH_MISALIGN_TRAP_EN: redirect to 0x102 → misalign_o=1, ird_o=0 thereafter. Redirect to 0x200 → misalign_o=0, fetch resumes at 0x200. Without the macro: fetch resumes at 0x100.
